// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: fetch-side bundle between the PC sequencer,
// instruction memory and the decode/execute consumer.
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt;
  logic        fetch_fault;

  modport master (
    output imem_req,
    output imem_addr,
    output inst_valid,
    output inst,
    output inst_pc,
    output fetch_fault,
    input  imem_ack,
    input  imem_rdata,
    input  inst_ready,
    input  branch_taken,
    input  branch_target,
    input  halt
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    input  fetch_fault,
    output imem_ack,
    output imem_rdata,
    output inst_ready,
    output branch_taken,
    output branch_target,
    output halt
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: multi-cycle fetch sequencer owning the PC.
// Ports: clock, reset_n (async low), bus (master: imem req/ack, inst valid/ready, branch, halt, fault).
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input logic             clock,
  input logic             reset_n,
  pc_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  // Last tolerated count value; the un-acked cycle that
  // reaches MAX_WAIT trips the fault.
  localparam logic [7:0] LP_LAST = 8'(MAX_WAIT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_inst;
  logic [31:0] w_inst_nxt;
  logic [31:0] r_inst_pc;
  logic [31:0] w_inst_pc_nxt;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_nxt;
  logic        w_br_bad;

  assign w_br_bad = bus.branch_taken &&
                    (bus.branch_target[1:0] != 2'b00);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_inst     <= 32'h0;
      r_inst_pc  <= 32'h0;
      r_wait_cnt <= 8'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_inst     <= w_inst_nxt;
      r_inst_pc  <= w_inst_pc_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_inst_nxt    = r_inst;
    w_inst_pc_nxt = r_inst_pc;
    w_wait_nxt    = r_wait_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (!bus.halt) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // halt is deliberately not looked at here: an
        // outstanding request always completes.
        if (bus.imem_ack) begin
          w_inst_nxt    = bus.imem_rdata;
          w_inst_pc_nxt = r_pc;
          w_wait_nxt    = 8'h0;
          w_state_nxt   = S_HOLD;
        end else if (r_wait_cnt == LP_LAST) begin
          w_wait_nxt  = r_wait_cnt + 8'h1;
          w_state_nxt = S_FAULT;
        end else begin
          w_wait_nxt = r_wait_cnt + 8'h1;
        end
      end
      S_HOLD: begin
        if (bus.inst_ready) begin
          if (w_br_bad) begin
            w_state_nxt = S_FAULT;
          end else begin
            if (bus.branch_taken) begin
              w_pc_nxt = bus.branch_target;
            end else begin
              w_pc_nxt = r_pc + 32'd4;
            end
            w_state_nxt = bus.halt ? S_IDLE : S_WAIT;
          end
        end
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs come from state and registers only.
  assign bus.imem_req    = (r_state == S_WAIT);
  assign bus.imem_addr   = r_pc;
  assign bus.inst_valid  = (r_state == S_HOLD);
  assign bus.inst        = r_inst;
  assign bus.inst_pc     = r_inst_pc;
  assign bus.fetch_fault = (r_state == S_FAULT);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed bench with a behavioural fetch model
// compared every cycle, plus literal spot checks.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RPC  = 32'h0;
  localparam int          MAXW = 3;
  localparam logic [31:0] KEY  = 32'h1357_9BDF;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  pc_fetch_ctrl_if bus();

  pc_fetch_ctrl #(.RESET_PC(RPC), .MAX_WAIT(MAXW)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Memory responder: ack during the lat-th cycle of a request.
  int lat = 2;
  bit force_ack = 0;
  int rc = 0;
  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
  end
  always @(posedge clock) begin
    #1;
    if (bus.imem_req) rc++;
    else rc = 0;
    bus.imem_ack = force_ack ||
      (bus.imem_req && lat != 0 && rc >= lat);
    bus.imem_rdata = bus.imem_ack ?
      (bus.imem_addr ^ KEY) : $urandom;
  end

  // Behavioural model: request outstanding / instruction held /
  // faulted flags, with the PC and the last captured word.
  bit          m_req, m_hold, m_fault;
  logic [31:0] m_pc, m_inst, m_ipc;
  int          m_wait;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_req = 0; m_hold = 0; m_fault = 0;
      m_pc = RPC; m_inst = 0; m_ipc = 0; m_wait = 0;
    end else if (m_fault) begin
      m_fault = 1;
    end else if (m_hold) begin
      if (bus.inst_ready) begin
        m_hold = 0;
        if (bus.branch_taken && bus.branch_target[1:0] != 0)
          m_fault = 1;
        else begin
          m_pc = bus.branch_taken ? bus.branch_target
                                  : m_pc + 32'd4;
          m_req = !bus.halt;
        end
      end
    end else if (m_req) begin
      if (bus.imem_ack) begin
        m_inst = bus.imem_rdata; m_ipc = m_pc;
        m_req = 0; m_hold = 1; m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait >= MAXW) begin
          m_req = 0; m_fault = 1;
        end
      end
    end else begin
      m_req = !bus.halt;
    end
  end

  always @(negedge clock) begin
    check("req",   {31'd0, bus.imem_req},    {31'd0, m_req});
    check("addr",  bus.imem_addr,            m_pc);
    check("valid", {31'd0, bus.inst_valid},  {31'd0, m_hold});
    check("inst",  bus.inst,                 m_inst);
    check("ipc",   bus.inst_pc,              m_ipc);
    check("fault", {31'd0, bus.fetch_fault}, {31'd0, m_fault});
  end

  task automatic wait_req(input logic [31:0] a);
    bit f = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.imem_req) begin f = 1; break; end
    end
    check("req_seen", {31'd0, f}, 32'd1);
    check("req_addr", bus.imem_addr, a);
  endtask

  task automatic wait_valid(input logic [31:0] a);
    bit f = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.inst_valid) begin f = 1; break; end
    end
    check("valid_seen", {31'd0, f}, 32'd1);
    check("valid_pc", bus.inst_pc, a);
    check("valid_inst", bus.inst, a ^ KEY);
  endtask

  task automatic rst_pulse();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
    check("rst_addr", bus.imem_addr, RPC);
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    bus.inst_ready = 1'b1;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'h0;
    bus.halt = 1'b0;
    repeat (2) @(negedge clock);
    check("r_req", {31'd0, bus.imem_req}, 32'd0);
    check("r_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("r_inst", bus.inst, 32'd0);
    check("r_ipc", bus.inst_pc, 32'd0);
    check("r_addr", bus.imem_addr, 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("first_idle", {31'd0, bus.imem_req}, 32'd0);

    // Sequential fetch, then branch at 0x8.
    wait_req(32'h0);   wait_valid(32'h0);
    wait_req(32'h4);   wait_valid(32'h4);
    wait_req(32'h8);   wait_valid(32'h8);
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h40;
    @(posedge clock);
    #1 bus.branch_taken = 1'b0;
    wait_req(32'h40);  wait_valid(32'h40);
    wait_req(32'h44);

    // Backpressure with changing rdata.
    bus.inst_ready = 1'b0;
    wait_valid(32'h44);
    repeat (5) begin
      @(negedge clock);
      check("bp_inst", bus.inst, 32'h1357_9B9B);
      check("bp_ipc", bus.inst_pc, 32'h44);
      check("bp_req", {31'd0, bus.imem_req}, 32'd0);
    end
    bus.inst_ready = 1'b1;
    wait_req(32'h48);  wait_valid(32'h48);

    // PC wrap.
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'hFFFF_FFFC;
    @(posedge clock);
    #1 bus.branch_taken = 1'b0;
    wait_req(32'hFFFF_FFFC);
    wait_valid(32'hFFFF_FFFC);
    wait_req(32'h0);

    // Halt during WAIT.
    bus.halt = 1'b1;
    wait_valid(32'h0);
    repeat (4) begin
      @(negedge clock);
      check("halt_req", {31'd0, bus.imem_req}, 32'd0);
      check("halt_valid", {31'd0, bus.inst_valid}, 32'd0);
    end
    bus.halt = 1'b0;
    wait_req(32'h4);

    // Async reset mid-WAIT.
    #2 reset_n = 1'b0;
    #1;
    check("async_req", {31'd0, bus.imem_req}, 32'd0);
    check("async_valid", {31'd0, bus.inst_valid}, 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    wait_req(32'h0);

    // Misaligned branch target.
    wait_valid(32'h0);
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h42;
    @(negedge clock);
    bus.branch_taken = 1'b0;
    check("mis_fault", {31'd0, bus.fetch_fault}, 32'd1);
    check("mis_pc", bus.imem_addr, 32'h0);
    repeat (4) begin
      @(negedge clock);
      check("mis_req", {31'd0, bus.imem_req}, 32'd0);
    end
    rst_pulse();

    // Timeout: never ack.
    lat = 0;
    rst_pulse();
    wait_req(32'h0);
    begin
      int cnt = 1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clock);
        if (bus.imem_req) cnt++;
        else break;
      end
      check("to_cycles", cnt, 32'd3);
    end
    check("to_fault", {31'd0, bus.fetch_fault}, 32'd1);
    force_ack = 1;
    repeat (3) begin
      @(negedge clock);
      check("late_fault", {31'd0, bus.fetch_fault}, 32'd1);
      check("late_req", {31'd0, bus.imem_req}, 32'd0);
      check("late_valid", {31'd0, bus.inst_valid}, 32'd0);
    end
    force_ack = 0;
    lat = 2;
    rst_pulse();
    wait_req(32'h0);
    wait_valid(32'h0);
    check("final_inst", bus.inst, 32'h1357_9BDF);

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Multi-cycle instruction-fetch sequencer that owns the program counter. It issues requests to instruction memory over a req/ack handshake with variable latency. It presents each fetched instruction to decode/execute under a valid/ready handshake, and it applies the branch decision (Branch && Zero, target from ALU) when that instruction retires. Wait-state timeout and misaligned branch targets are detected and reported as a sticky fault.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
MAX_WAIT, 15, number of consecutive un-acked request cycles tolerated before fault; range 1..255.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address, equal to current PC.
imem_ack  input  1  memory returns data this cycle.
imem_rdata  input  32  instruction word, valid when imem_ack=1.
inst_valid  output  1  fetched instruction available.
inst  output  32  fetched instruction word.
inst_pc  output  32  PC of inst; this is the branch base address sent to the ALU.
inst_ready  input  1  consumer accepts inst this cycle.
branch_taken  input  1  Branch && Zero for the instruction being accepted.
branch_target  input  32  ALU-computed branch address.
halt  input  1  stop fetching at the next instruction boundary.
fetch_fault  output  1  sticky error flag.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, pc=RESET_PC, wait_cnt=0. Outputs: imem_req=0, inst_valid=0, inst=0, inst_pc=0, fetch_fault=0. imem_addr=pc.
- All outputs are registered or decoded from state only; no input-to-output combinational paths.
- States: IDLE, WAIT, HOLD, FAULT.
- IDLE: imem_req=0, inst_valid=0. If halt=0, go to WAIT on the next edge; otherwise stay. First request is therefore asserted 1 cycle after reset release.
- WAIT: imem_req=1, imem_addr=pc, held stable until ack.
  - On imem_ack=1: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, wait_cnt<=0, go to HOLD.
  - Otherwise wait_cnt++. If wait_cnt reaches MAX_WAIT with no ack, go to FAULT; fetch_fault<=1, imem_req<=0.
  - halt is ignored in WAIT; an outstanding request is never abandoned.
- HOLD: inst_valid=1; inst and inst_pc are stable; imem_req=0.
  - Handshake occurs when inst_ready=1. branch_taken and branch_target are sampled only on the handshake edge.
  - If branch_taken=1 and branch_target[1:0]!=0: go to FAULT, fetch_fault<=1, pc unchanged.
  - If branch_taken=1 and the target is aligned: pc<=branch_target.
  - If branch_taken=0: pc<=pc+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - inst_valid<=0 on the handshake. Go to IDLE if halt=1, else go to WAIT.
  - Back-to-back throughput is therefore 1 instruction per (ack latency + 2) cycles minimum.
- FAULT: imem_req=0, inst_valid=0, fetch_fault=1. Exit only via reset.
- imem_ack in any state other than WAIT is ignored. This includes a late ack arriving after reset.
- Reset asserted mid-transaction drops imem_req and inst_valid immediately (asynchronous).
- halt deasserted while in IDLE resumes fetch at the retained pc.

Test Plan:
- Reset release, imem_ack returned 2 cycles after each req, inst_ready held 1, branch_taken=0 -> imem_addr sequence 0x0, 0x4, 0x8; inst_pc matches each; inst_valid high for exactly 1 cycle per instruction.
- Branch: in HOLD with inst_pc=0x8, present inst_ready=1, branch_taken=1, branch_target=0x40 -> next imem_addr=0x40; a following non-branch instruction fetches 0x44.
- Backpressure: inst_ready=0 for 5 cycles in HOLD while imem_rdata changes -> inst and inst_pc stay stable, imem_req=0; on inst_ready=1 the next req is issued at pc+4.
- Timeout: MAX_WAIT=3, never ack -> imem_req high for 3 cycles, then fetch_fault=1 and imem_req=0; a later ack changes nothing; reset_n pulse clears the fault and restarts at RESET_PC.
- Misaligned branch: branch_target=0x42 with branch_taken=1 on handshake -> fetch_fault=1, no further requests. Separately, pc=0xFFFF_FFFC non-branch retire -> next imem_addr=0x0.
- Halt/async reset: halt=1 during WAIT -> the ack is still taken and the instruction retires, then the block stays in IDLE with no req until halt=0. Asserting reset_n=0 mid-WAIT drops imem_req in the same cycle without a clock edge.
